fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline; the producer side of the IF/ID pipeline register.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready request channel plus a response-valid return.
- Presents instr / PCf / PCPlus4F to the IF/ID register and reports FetchBusy to the hazard unit, which converts it into an ID bubble.
- Honours StallF and branch/jump redirects from Execute, including redirects that arrive while a request is in flight.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- StallF  input  1  hazard unit: hold the current fetch; do not advance the PC.
- RedirectE  input  1  Execute: branch taken or jump; load PCTargetE.
- PCTargetE  input  DATA_WIDTH  redirect target; bits [1:0] are forced to 0 internally.
- imem_req_valid  output  1  request valid.
- imem_req_addr  output  DATA_WIDTH  request address (the current PC).
- imem_req_ready  input  1  memory accepts the request.
- imem_resp_valid  input  1  response data is valid.
- imem_resp_data  input  DATA_WIDTH  fetched instruction.
- instr  output  DATA_WIDTH  instruction to the IF/ID register.
- PCf  output  DATA_WIDTH  PC of instr.
- PCPlus4F  output  DATA_WIDTH  PCf + 4, modulo 2^DATA_WIDTH.
- FetchValid  output  1  instr/PCf/PCPlus4F hold a valid instruction.
- FetchBusy  output  1  equal to !FetchValid; to the hazard unit.

Behaviour:
- States:
  - IDLE: post-reset only.
  - REQ: request driven.
  - WAIT: request accepted, awaiting response.
  - VALID: instruction presented.
  - DROP: discard a stale response.
- Reset (async, while rst is high):
  - state=IDLE, PC=RESET_PC, instruction buffer=0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr=0, PCf=RESET_PC, PCPlus4F=RESET_PC+4, FetchValid=0, FetchBusy=1.
- Output decode:
  - imem_req_valid=1 only in REQ.
  - imem_req_addr=PC in all states.
  - instr=buffer in VALID, else 0.
  - PCf=PC, PCPlus4F=PC+4 at all times.
  - FetchValid=1 only in VALID.
- Acceptance: a request is accepted in a cycle where imem_req_valid and imem_req_ready are both 1.
- Response timing:
  - imem_resp_valid arrives at least 1 cycle after acceptance, exactly once per accepted request.
  - The block ignores imem_resp_valid in IDLE, REQ and VALID.
- Transitions, with RedirectE taking priority over everything else:
  - IDLE -> REQ unconditionally.
  - REQ: accepted -> WAIT; otherwise stay in REQ and hold the address.
  - WAIT: imem_resp_valid -> buffer <= imem_resp_data, go to VALID. FetchValid rises the cycle after the response (1-cycle registered latency).
  - VALID, StallF=1: stay; buffer, PC and outputs are frozen.
  - VALID, StallF=0: the IF/ID register captures this cycle; PC <= PC+4, go to REQ.
  - DROP: imem_resp_valid -> discard data, go to REQ.
- Redirect (RedirectE=1), applied at the clock edge regardless of StallF:
  - PC <= {PCTargetE[DATA_WIDTH-1:2], 2'b00}.
  - IDLE or VALID -> REQ; the buffered instruction is discarded and FetchValid=0 next cycle.
  - REQ and not accepted this cycle -> REQ. No transaction exists yet, so the address may change.
  - REQ and accepted this cycle -> DROP.
  - WAIT with no response this cycle -> DROP.
  - WAIT with a response this cycle -> discard the response, go to REQ.
  - DROP with a response this cycle -> REQ; without a response -> stay in DROP. PC is updated in both cases.
- Limits and wrap-around:
  - At most one outstanding request ever.
  - PC wraps 0xFFFF_FFFC -> 0x0000_0000.
- StallF outside VALID has no effect on the handshake; a miss in progress completes.
- rst asserted mid-transaction: return to reset values immediately; a later in-flight response is ignored, since IDLE ignores responses.

Test Plan:
- Reset release, RESET_PC=0, memory ready=1, 1-cycle response of 0x00500093 -> IDLE then REQ with addr 0; VALID two cycles after acceptance; instr=0x00500093, PCf=0, PCPlus4F=4; next request addr=4.
- StallF=1 held 3 cycles in VALID with instr=0x00A00113, PCf=8 -> outputs frozen, no new request; StallF=0 -> REQ with addr 0xC.
- RedirectE=1 with PCTargetE=0x103 in WAIT, then response 0xDEADBEEF -> DROP, response discarded, FetchValid stays 0; next request addr=0x100.
- RedirectE and imem_resp_valid in the same WAIT cycle -> response dropped, REQ addr=target, no VALID for the old PC.
- imem_req_ready low 5 cycles in REQ at addr 0x20 -> imem_req_valid high and addr=0x20 stable throughout; acceptance on cycle 6 -> WAIT.
- rst pulsed while in WAIT, then a stray response -> all outputs at reset values; stray response ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request
// at a time and presents the fetched instruction to the IF/ID register.
//
// Ports:
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   StallF              hold the presented instruction and PC
//   RedirectE           load PCTargetE (word-aligned) as the next PC
//   PCTargetE           redirect target
//   imem_req_valid      request valid (only while a request is being offered)
//   imem_req_addr       request address, always the current PC
//   imem_req_ready      memory accepts the request
//   imem_resp_valid     response strobe, once per accepted request
//   imem_resp_data      fetched instruction
//   instr, PCf, PCPlus4F  instruction and its PC / PC+4 to IF/ID
//   FetchValid          instr/PCf/PCPlus4F hold a valid instruction
//   FetchBusy           complement of FetchValid, to the hazard unit
module fetch_unit #(
  parameter int unsigned               DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  RedirectE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req_valid,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] PCf,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  FetchValid,
  output logic                  FetchBusy
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_DROP  = 3'd4
  } state_t;

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   pc, pc_n;
  logic [DATA_WIDTH-1:0]   buffer, buffer_n;
  logic [DATA_WIDTH-1:0]   target;
  logic                    accepted;

  // Redirect targets are always word aligned.
  assign target   = PCTargetE & ALIGN_MASK;
  assign accepted = (state == S_REQ) && imem_req_ready;

  // Next-state, next-PC and instruction buffer; a redirect overrides everything.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    buffer_n = buffer;
    if (RedirectE) begin
      pc_n = target;
      unique case (state)
        S_REQ:   state_n = accepted ? S_DROP : S_REQ;
        // A response in the same cycle closes the transaction, so no drop needed.
        S_WAIT:  state_n = imem_resp_valid ? S_REQ : S_DROP;
        S_DROP:  state_n = imem_resp_valid ? S_REQ : S_DROP;
        default: state_n = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_IDLE:  state_n = S_REQ;
        S_REQ:   state_n = accepted ? S_WAIT : S_REQ;
        S_WAIT: begin
          if (imem_resp_valid) begin
            buffer_n = imem_resp_data;
            state_n  = S_VALID;
          end
        end
        S_VALID: begin
          if (!StallF) begin
            pc_n    = pc + PC_STEP;
            state_n = S_REQ;
          end
        end
        S_DROP:  state_n = imem_resp_valid ? S_REQ : S_DROP;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State, PC, buffer and registered output decode of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      buffer         <= '0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      instr          <= '0;
      PCf            <= RESET_PC;
      PCPlus4F       <= RESET_PC + PC_STEP;
      FetchValid     <= 1'b0;
      FetchBusy      <= 1'b1;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      buffer         <= buffer_n;
      imem_req_valid <= (state_n == S_REQ);
      imem_req_addr  <= pc_n;
      instr          <= (state_n == S_VALID) ? buffer_n : '0;
      PCf            <= pc_n;
      PCPlus4F       <= pc_n + PC_STEP;
      FetchValid     <= (state_n == S_VALID);
      FetchBusy      <= (state_n != S_VALID);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: drives the memory side by hand and checks
// outputs one time unit after each rising edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, RedirectE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready, imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instr, PCf, PCPlus4F;
  logic        FetchValid, FetchBusy;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .StallF         (StallF),
    .RedirectE      (RedirectE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr          (instr),
    .PCf            (PCf),
    .PCPlus4F       (PCPlus4F),
    .FetchValid     (FetchValid),
    .FetchBusy      (FetchBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept the pending request, return data one cycle later, land in VALID.
  task automatic fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    tick();
    imem_resp_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, ".addr"},      imem_req_addr, 32'h0);
    chk({tag, ".instr"},     instr, 32'h0);
    chk({tag, ".pcf"},       PCf, 32'h0);
    chk({tag, ".pcp4"},      PCPlus4F, 32'h4);
    chk({tag, ".fvalid"},    32'(FetchValid), 32'd0);
    chk({tag, ".fbusy"},     32'(FetchBusy), 32'd1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; StallF = 1'b0; RedirectE = 1'b0; PCTargetE = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    tick(); tick();
    chk_reset_outputs("rst");

    // Basic fetch from RESET_PC.
    rst = 1'b0;
    tick();
    chk("t1.req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1.addr", imem_req_addr, 32'h0);
    tick();
    chk("t1.wait_req", 32'(imem_req_valid), 32'd0);
    chk("t1.wait_busy", 32'(FetchBusy), 32'd1);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00500093;
    tick();
    imem_resp_valid = 1'b0;
    chk("t1.fvalid", 32'(FetchValid), 32'd1);
    chk("t1.fbusy", 32'(FetchBusy), 32'd0);
    chk("t1.instr", instr, 32'h00500093);
    chk("t1.pcf", PCf, 32'h0);
    chk("t1.pcp4", PCPlus4F, 32'h4);
    tick();
    chk("t1.next_addr", imem_req_addr, 32'h4);
    chk("t1.next_req", 32'(imem_req_valid), 32'd1);

    // Stall held in VALID at PC 8.
    fetch(32'h00200093);
    tick();
    fetch(32'h00A00113);
    StallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2.fvalid", 32'(FetchValid), 32'd1);
      chk("t2.instr", instr, 32'h00A00113);
      chk("t2.pcf", PCf, 32'h8);
      chk("t2.req_valid", 32'(imem_req_valid), 32'd0);
    end
    StallF = 1'b0;
    tick();
    chk("t2.req_valid_after", 32'(imem_req_valid), 32'd1);
    chk("t2.addr_after", imem_req_addr, 32'hC);

    // Redirect in WAIT, stale response dropped.
    tick();
    RedirectE = 1'b1; PCTargetE = 32'h103;
    tick();
    RedirectE = 1'b0;
    chk("t3.drop_addr", imem_req_addr, 32'h100);
    chk("t3.drop_req", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEADBEEF;
    tick();
    imem_resp_valid = 1'b0;
    chk("t3.fvalid", 32'(FetchValid), 32'd0);
    chk("t3.req_valid", 32'(imem_req_valid), 32'd1);
    chk("t3.addr", imem_req_addr, 32'h100);

    // Redirect coinciding with the response in WAIT.
    tick();
    RedirectE = 1'b1; PCTargetE = 32'h200;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h11111111;
    tick();
    RedirectE = 1'b0; imem_resp_valid = 1'b0;
    chk("t4.req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4.addr", imem_req_addr, 32'h200);
    chk("t4.fvalid", 32'(FetchValid), 32'd0);
    chk("t4.instr", instr, 32'h0);

    // Unaccepted request redirected, then back-pressure at 0x20.
    imem_req_ready = 1'b0;
    RedirectE = 1'b1; PCTargetE = 32'h20;
    tick();
    RedirectE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5.req_valid", 32'(imem_req_valid), 32'd1);
      chk("t5.addr", imem_req_addr, 32'h20);
      if (i < 4) tick();
    end
    imem_req_ready = 1'b1;
    tick();
    chk("t5.wait_req", 32'(imem_req_valid), 32'd0);
    chk("t5.wait_busy", 32'(FetchBusy), 32'd1);
    chk("t5.wait_addr", imem_req_addr, 32'h20);

    // Asynchronous reset in WAIT, then a stray response.
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6.async");
    imem_req_ready = 1'b0;
    tick();
    rst = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBADBAD00;
    tick();
    imem_resp_valid = 1'b0;
    chk("t6.req_valid", 32'(imem_req_valid), 32'd1);
    chk("t6.addr", imem_req_addr, 32'h0);
    chk("t6.fvalid", 32'(FetchValid), 32'd0);
    fetch(32'h12345678);
    chk("t6.instr", instr, 32'h12345678);
    chk("t6.pcf", PCf, 32'h0);

    // Redirect out of VALID to the top word, then PC wrap.
    RedirectE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
    StallF = 1'b1;
    tick();
    RedirectE = 1'b0; StallF = 1'b0;
    chk("t7.fvalid", 32'(FetchValid), 32'd0);
    chk("t7.addr", imem_req_addr, 32'hFFFF_FFFC);
    fetch(32'hCAFEF00D);
    chk("t7.pcf", PCf, 32'hFFFF_FFFC);
    chk("t7.pcp4", PCPlus4F, 32'h0);
    chk("t7.instr", instr, 32'hCAFEF00D);
    tick();
    chk("t7.wrap_addr", imem_req_addr, 32'h0);
    chk("t7.wrap_req", 32'(imem_req_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
